imm_gen_stage: RTL and testbench

Registered, parametrised immediate generator for the decode stage, successor to the combinational extender. It extracts and sign-extends I/S/B/U/J immediates to `DATA_WIDTH`, adds the CSR zero-extended immediate (Z-type), and computes the PC-relative target `pc + imm`. It flags unsupported `imm_src_i` codes, and sits between fetch/decode and execute behind a valid/ready handshake with a 2-entry skid buffer, stall and flush.

---
 rtl/imm_pkg.sv | 29 ++
 rtl/imm_decode.sv | 42 ++++
 rtl/imm_gen_stage.sv | 116 +++++++++++
 tb/tb_imm_gen_stage.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared types for the decode-stage immediate generator: format codes,
// skid-buffer states and the registered entry layout.
package imm_pkg;

    localparam int unsigned IMM_INSTR_WIDTH = 32;
    localparam int unsigned IMM_DATA_WIDTH  = 32;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_B = 3'b001,
        IMM_S = 3'b010,
        IMM_U = 3'b011,
        IMM_J = 3'b100,
        IMM_Z = 3'b101
    } imm_src_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_BUSY  = 2'b01,
        ST_FULL  = 2'b10
    } stage_state_e;

    typedef struct packed {
        logic [IMM_DATA_WIDTH-1:0] imm;
        logic [IMM_DATA_WIDTH-1:0] target;
        logic                      illegal;
    } imm_entry_t;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate extraction for all supported formats plus the
// flag for unsupported select codes.
module imm_decode
    import imm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned INSTR_WIDTH = 32
) (
    input  logic [INSTR_WIDTH-1:0] instr_i,
    input  logic [2:0]             imm_src_i,
    output logic [DATA_WIDTH-1:0]  imm_o,
    output logic                   illegal_o
);

    logic [31:0] imm32_s;
    logic        unused_opcode_s;

    assign unused_opcode_s = ^instr_i[6:0];

    // Build a 32-bit sign-correct value; Z-type has bit 31 clear so the common widening also zero-extends it
    always_comb begin
        imm32_s   = 32'd0;
        illegal_o = 1'b0;
        case (imm_src_i)
            IMM_I:   imm32_s = {{20{instr_i[31]}}, instr_i[31:20]};
            IMM_B:   imm32_s = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                                instr_i[30:25], instr_i[11:8], 1'b0};
            IMM_S:   imm32_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IMM_U:   imm32_s = {instr_i[31:12], 12'd0};
            IMM_J:   imm32_s = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                                instr_i[20], instr_i[30:21], 1'b0};
            IMM_Z:   imm32_s = {27'd0, instr_i[19:15]};
            default: begin
                imm32_s   = 32'd0;
                illegal_o = 1'b1;
            end
        endcase
    end

    assign imm_o = DATA_WIDTH'($signed(imm32_s));

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate generator stage: decodes the immediate, computes the
// PC-relative target and hands entries downstream through a 2-entry skid buffer.
module imm_gen_stage
    import imm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned INSTR_WIDTH = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [2:0]             imm_src_i,
    input  logic [INSTR_WIDTH-1:0] instr_i,
    input  logic [DATA_WIDTH-1:0]  pc_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [DATA_WIDTH-1:0]  imm_ext_o,
    output logic [DATA_WIDTH-1:0]  target_o,
    output logic                   illegal_o
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] imm;
        logic [DATA_WIDTH-1:0] target;
        logic                  illegal;
    } entry_t;

    stage_state_e state_q, state_d;
    entry_t       out_q, out_d;
    entry_t       skid_q, skid_d;
    entry_t       new_s;
    logic [DATA_WIDTH-1:0] dec_imm_s;
    logic         dec_illegal_s;
    logic         in_fire_s;
    logic         out_fire_s;

    imm_decode #(
        .DATA_WIDTH (DATA_WIDTH),
        .INSTR_WIDTH(INSTR_WIDTH)
    ) u_imm_decode (
        .instr_i  (instr_i),
        .imm_src_i(imm_src_i),
        .imm_o    (dec_imm_s),
        .illegal_o(dec_illegal_s)
    );

    assign new_s.imm     = dec_imm_s;
    assign new_s.target  = pc_i + dec_imm_s;
    assign new_s.illegal = dec_illegal_s;

    assign ready_o    = (state_q != ST_FULL);
    assign valid_o    = (state_q != ST_EMPTY);
    assign in_fire_s  = valid_i & ready_o;
    assign out_fire_s = valid_o & ready_i;

    // Next-state and data routing; flush overrides every transition and drops the same-cycle input
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire_s) begin
                        out_d   = new_s;
                        state_d = ST_BUSY;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_BUSY: begin
                    case ({in_fire_s, out_fire_s})
                        2'b10: begin
                            skid_d  = new_s;
                            state_d = ST_FULL;
                        end
                        2'b01: state_d = ST_EMPTY;
                        2'b11: out_d   = new_s;
                        default: state_d = ST_BUSY;
                    endcase
                end
                ST_FULL: begin
                    if (out_fire_s) begin
                        out_d   = skid_q;
                        state_d = ST_BUSY;
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // State and entry registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
        end
    end

    assign imm_ext_o = out_q.imm;
    assign target_o  = out_q.target;
    assign illegal_o = out_q.illegal;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Randomised and directed bench for imm_gen_stage at 32 and 64 bits against
// an arithmetic immediate model and a 2-deep queue model of the buffer.
module tb_imm_gen_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        valid_in;
    logic        ready_in;
    logic [2:0]  src;
    logic [31:0] instr;
    logic [63:0] pc64;

    logic        ready32, valid32, ill32;
    logic [31:0] imm32, tgt32;
    logic        ready64, valid64, ill64;
    logic [63:0] imm64, tgt64;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [63:0] imm;
        logic [63:0] tgt;
        logic        ill;
    } exp_t;

    exp_t q[$];

    imm_gen_stage #(.DATA_WIDTH(32)) dut32 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(valid_in),
        .ready_o(ready32), .imm_src_i(src), .instr_i(instr), .pc_i(pc64[31:0]),
        .valid_o(valid32), .ready_i(ready_in), .imm_ext_o(imm32),
        .target_o(tgt32), .illegal_o(ill32)
    );

    imm_gen_stage #(.DATA_WIDTH(64)) dut64 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(valid_in),
        .ready_o(ready64), .imm_src_i(src), .instr_i(instr), .pc_i(pc64),
        .valid_o(valid64), .ready_i(ready_in), .imm_ext_o(imm64),
        .target_o(tgt64), .illegal_o(ill64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Immediate value computed from field weights, independent of bit concatenation
    function automatic exp_t ref_entry(input logic [31:0] ins, input logic [2:0] s,
                                       input logic [63:0] pc);
        exp_t   e;
        longint v;
        longint sgn;
        sgn   = longint'(int'(ins) >>> 31);
        e.ill = 1'b0;
        case (s)
            3'd0: v = longint'(int'(ins) >>> 20);
            3'd1: v = sgn * 64'sd4096 + longint'(ins[7]) * 64'sd2048
                      + longint'(ins[30:25]) * 64'sd32 + longint'(ins[11:8]) * 64'sd2;
            3'd2: v = longint'(int'(ins) >>> 25) * 64'sd32 + longint'(ins[11:7]);
            3'd3: v = longint'(int'(ins & 32'hFFFFF000));
            3'd4: v = sgn * 64'sd1048576 + longint'(ins[19:12]) * 64'sd4096
                      + longint'(ins[20]) * 64'sd2048 + longint'(ins[30:21]) * 64'sd2;
            3'd5: v = longint'(ins[19:15]);
            default: begin
                v     = 64'sd0;
                e.ill = 1'b1;
            end
        endcase
        e.imm = v;
        e.tgt = pc + v;
        return e;
    endfunction

    task automatic compare_outputs();
        check("valid32", valid32, q.size() > 0);
        check("ready32", ready32, q.size() < 2);
        check("valid64", valid64, q.size() > 0);
        check("ready64", ready64, q.size() < 2);
        if (q.size() > 0) begin
            check("imm32", imm32, q[0].imm[31:0]);
            check("tgt32", tgt32, q[0].tgt[31:0]);
            check("ill32", ill32, q[0].ill);
            check("imm64", imm64, q[0].imm);
            check("tgt64", tgt64, q[0].tgt);
            check("ill64", ill64, q[0].ill);
        end
    endtask

    task automatic step();
        logic in_fire;
        logic out_fire;
        @(posedge clk);
        in_fire  = valid_in && (q.size() < 2);
        out_fire = (q.size() > 0) && ready_in;
        if (!rst_n || flush) begin
            q.delete();
        end else begin
            if (out_fire) void'(q.pop_front());
            if (in_fire) q.push_back(ref_entry(instr, src, pc64));
        end
        #1;
        compare_outputs();
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [2:0] s,
                         input logic [63:0] pc);
        valid_in = v;
        instr    = ins;
        src      = s;
        pc64     = pc;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid32"}, valid32, 1'b0);
        check({tag, "_ready32"}, ready32, 1'b1);
        check({tag, "_imm32"}, imm32, 32'd0);
        check({tag, "_tgt32"}, tgt32, 32'd0);
        check({tag, "_ill32"}, ill32, 1'b0);
        check({tag, "_valid64"}, valid64, 1'b0);
        check({tag, "_imm64"}, imm64, 64'd0);
        check({tag, "_tgt64"}, tgt64, 64'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        flush    = 1'b0;
        ready_in = 1'b1;
        drive(1'b0, 32'd0, 3'd0, 64'd0);
        #12;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Directed format vectors, one cycle after accept
        drive(1'b1, 32'hFFF00093, 3'b000, 64'h0);
        step();
        check("I_imm", imm32, 32'hFFFFFFFF);
        check("I_tgt", tgt32, 32'hFFFFFFFF);
        check("I_ill", ill32, 1'b0);
        check("I_imm64", imm64, 64'hFFFFFFFFFFFFFFFF);
        drive(1'b1, 32'hFE000EE3, 3'b001, 64'h100);
        step();
        check("B_imm", imm32, 32'hFFFFFFFC);
        check("B_tgt", tgt32, 32'h000000FC);
        drive(1'b1, 32'h123450B7, 3'b011, 64'h0);
        step();
        check("U_imm", imm32, 32'h12345000);
        drive(1'b1, 32'h0080006F, 3'b100, 64'h200);
        step();
        check("J_imm", imm32, 32'h00000008);
        check("J_tgt", tgt32, 32'h00000208);
        drive(1'b1, 32'h000F8073, 3'b101, 64'h0);
        step();
        check("Z_imm64", imm64, 64'h000000000000001F);
        drive(1'b1, 32'hFFFFFFFF, 3'b110, 64'h40);
        step();
        check("ill_imm", imm32, 32'h0);
        check("ill_flag", ill32, 1'b1);
        drive(1'b1, 32'hFE112E23, 3'b010, 64'h0);
        step();
        check("S_imm64", imm64, 64'hFFFFFFFFFFFFFFFC);
        drive(1'b1, 32'h0, 3'b000, 64'hFFFFFFFFFFFFFFFF);
        step();
        check("wrap_tgt64", tgt64, 64'hFFFFFFFFFFFFFFFF);
        drive(1'b0, 32'h0, 3'b000, 64'h0);
        step();

        // Backpressure: three back-to-back offers with downstream stalled
        ready_in = 1'b0;
        drive(1'b1, 32'h11111037, 3'b011, 64'h0);
        step();
        check("bp_ready1", ready32, 1'b1);
        drive(1'b1, 32'h22222037, 3'b011, 64'h0);
        step();
        check("bp_ready2", ready32, 1'b0);
        drive(1'b1, 32'h33333037, 3'b011, 64'h0);
        step();
        check("bp_hold_imm", imm32, 32'h11111000);
        drive(1'b0, 32'h0, 3'b000, 64'h0);
        ready_in = 1'b1;
        step();
        check("bp_drain2", imm32, 32'h22222000);
        check("bp_ready3", ready32, 1'b1);
        step();
        check("bp_empty", valid32, 1'b0);

        // Flush while full with a valid offer pending
        ready_in = 1'b0;
        drive(1'b1, 32'h44444037, 3'b011, 64'h0);
        step();
        step();
        flush = 1'b1;
        drive(1'b1, 32'h55555037, 3'b011, 64'h0);
        step();
        check("flush_valid", valid32, 1'b0);
        check("flush_ready", ready32, 1'b1);
        flush = 1'b0;
        ready_in = 1'b1;
        drive(1'b0, 32'h0, 3'b000, 64'h0);
        for (int i = 0; i < 3; i++) step();

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(3, 0) != 0, $urandom, 3'($urandom_range(7, 0)),
                  {$urandom, $urandom});
            ready_in = $urandom_range(9, 0) < 7;
            flush    = $urandom_range(19, 0) == 0;
            step();
        end
        flush = 1'b0;

        // Asynchronous reset mid-stream
        ready_in = 1'b0;
        drive(1'b1, 32'h12345037, 3'b011, 64'h10);
        step();
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        q.delete();
        #2;
        rst_n = 1'b1;
        ready_in = 1'b1;
        drive(1'b1, 32'hFFF00093, 3'b000, 64'h4);
        step();
        check("post_rst_accept", valid32, 1'b1);
        check("post_rst_tgt", tgt32, 32'h00000003);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
